// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and instruction constants for the fetch unit
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_WORD    = 16'h0000;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: load/control/issue bundle between the fetch unit and its host/datapath
interface instr_fetch_if #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          start;
    logic          stall;
    logic [15:0]   Instruction;
    logic          InitSel;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;
    modport master (
        output load_en, load_addr, load_data, start, stall,
        input  Instruction, InitSel, instr_valid, pc, halted
    );
    modport slave (
        input  load_en, load_addr, load_data, start, stall,
        output Instruction, InitSel, instr_valid, pc, halted
    );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: program buffer, synchronous write and asynchronous read, no reset
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);
    logic [15:0] mem_q [DEPTH];
    // store one word per cycle when enabled; contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IDLE/RUN/HALT fetch sequencer over prog_mem; FETCH_HALT_OP_EN enables the halt opcode
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input logic          clk,
    input logic          reset,
    instr_fetch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef FETCH_HALT_OP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    fetch_state_e  state_q;
    logic [AW-1:0] pc_q;
    logic [15:0]   instr_q;
    logic [15:0]   rd_data;
    logic          valid_q;
    logic          init_sel_q;
    logic          halted_q;
    logic          we_d;
    logic          is_halt;
    // loads are only accepted while not executing
    assign we_d    = bus.load_en && (state_q != RUN);
    assign is_halt = HALT_EN && (rd_data[15:12] == HALT_OPCODE);
    prog_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .we_i   (we_d),
        .waddr_i(bus.load_addr),
        .wdata_i(bus.load_data),
        .raddr_i(pc_q),
        .rdata_o(rd_data)
    );
    // sequencer with registered outputs; issue word at pc and advance unless stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
            init_sel_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (!bus.stall) begin
                        if (is_halt) begin
                            state_q    <= HALT;
                            instr_q    <= NOP_WORD;
                            init_sel_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end else begin
                            instr_q <= rd_data;
                            valid_q <= 1'b1;
                            pc_q    <= pc_q + 1'b1;
                        end
                    end
                end
                IDLE, HALT: begin
                    if (bus.start) begin
                        state_q    <= RUN;
                        pc_q       <= '0;
                        init_sel_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    pc_q       <= '0;
                    instr_q    <= NOP_WORD;
                    init_sel_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end
    assign bus.Instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.InitSel     = init_sel_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus random traffic checked against a behavioural fetch model
module tb_instr_fetch;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
`ifdef FETCH_HALT_OP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    instr_fetch_if #(.DEPTH(DEPTH)) bus ();
    instr_fetch #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // reference: mode 0 = stopped, 1 = executing, 2 = stopped on halt word
    int          m_mode = 0;
    int          m_pc = 0;
    logic [15:0] m_ins = 16'h0;
    bit          m_vld = 1'b0;
    bit          m_hlt = 1'b0;
    logic [15:0] m_mem [DEPTH];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic model_step(input int r, input int le, input int la, input int ld, input int st, input int sl);
        logic [15:0] w;
        m_vld = 1'b0;
        if (r != 0) begin
            m_mode = 0; m_pc = 0; m_ins = 16'h0; m_hlt = 1'b0;
        end else if (m_mode == 1) begin
            if (sl == 0) begin
                w = m_mem[m_pc];
                if (HALT_EN && w[15:12] == 4'hF) begin
                    m_mode = 2; m_ins = 16'h0; m_hlt = 1'b1;
                end else begin
                    m_ins = w; m_vld = 1'b1; m_pc = (m_pc + 1) % DEPTH;
                end
            end
        end else begin
            if (le != 0) m_mem[la % DEPTH] = 16'(ld);
            if (st != 0) begin
                m_mode = 1; m_pc = 0; m_hlt = 1'b0;
            end
        end
    endtask
    task automatic tick(input int r, input int le, input int la, input int ld, input int st, input int sl);
        reset         = (r != 0);
        bus.load_en   = (le != 0);
        bus.load_addr = AW'(la);
        bus.load_data = 16'(ld);
        bus.start     = (st != 0);
        bus.stall     = (sl != 0);
        @(posedge clk);
        model_step(r, le, la, ld, st, sl);
        #1;
        chk("ins",  32'(bus.Instruction), 32'(m_ins));
        chk("vld",  32'(bus.instr_valid), 32'(m_vld));
        chk("isel", 32'(bus.InitSel),     32'(m_mode == 1));
        chk("pc",   32'(bus.pc),          32'(m_pc));
        chk("hlt",  32'(bus.halted),      32'(m_hlt));
    endtask
    initial begin
        logic [15:0] prog [4];
        logic [15:0] prev;
        bit          found;
        prog[0] = 16'h1123; prog[1] = 16'h2456; prog[2] = 16'h3789; prog[3] = 16'hF000;
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("rst_ins", 32'(bus.Instruction), 32'h0);
        chk("rst_isel", 32'(bus.InitSel), 32'h0);
        for (int i = 0; i < 4; i++) tick(0, 1, i, int'(prog[i]), 0, 0);
        tick(0, 0, 0, 0, 1, 0);
        chk("run_isel", 32'(bus.InitSel), 32'h1);
        tick(0, 0, 0, 0, 0, 0);
        chk("r33_w0", 32'(bus.Instruction), 32'h1123);
        tick(0, 0, 0, 0, 0, 0);
        chk("r33_w1", 32'(bus.Instruction), 32'h2456);
        tick(0, 0, 0, 0, 0, 0);
        chk("r33_w2", 32'(bus.Instruction), 32'h3789);
        chk("r33_vld", 32'(bus.instr_valid), 32'h1);
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 0, 0, 1);
            chk("r34_hold", 32'(bus.Instruction), 32'h1123);
            chk("r34_vld", 32'(bus.instr_valid), 32'h0);
            chk("r34_pc", 32'(bus.pc), 32'h1);
        end
        tick(0, 0, 0, 0, 0, 0);
        chk("r34_next", 32'(bus.Instruction), 32'h2456);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
`ifdef FETCH_HALT_OP_EN
        chk("r35_hlt", 32'(bus.halted), 32'h1);
        chk("r35_pc", 32'(bus.pc), 32'h3);
        chk("r35_isel", 32'(bus.InitSel), 32'h0);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("r35_re", 32'(bus.Instruction), 32'h1123);
`else
        chk("r36_f000", 32'(bus.Instruction), 32'hF000);
        tick(0, 0, 0, 0, 0, 0);
        chk("r36_wrap0", 32'(bus.Instruction), 32'h1123);
        tick(0, 0, 0, 0, 0, 0);
        chk("r36_wrap1", 32'(bus.Instruction), 32'h2456);
        chk("r36_hlt", 32'(bus.halted), 32'h0);
`endif
        tick(1, 0, 0, 0, 0, 0);
        chk("r37_pc", 32'(bus.pc), 32'h0);
        chk("r37_ins", 32'(bus.Instruction), 32'h0);
        chk("r37_isel", 32'(bus.InitSel), 32'h0);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("r37_mem", 32'(bus.Instruction), 32'h1123);
        tick(0, 1, 1, 16'hAAAA, 0, 0);
        prev = bus.Instruction;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick(0, 0, 0, 0, 1, 0);
            if (bus.instr_valid) begin
                if (prev == 16'h1123) begin
                    chk("r38_rewrap", 32'(bus.Instruction), 32'h2456);
                    found = 1'b1;
                end
                prev = bus.Instruction;
            end
        end
        chk("r38_found", 32'(found), 32'h1);
        for (int k = 0; k < 600; k++) begin
            int d;
            d = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) d = d | 32'hF000;
            tick(($urandom_range(0, 49) == 0) ? 1 : 0,
                 ($urandom_range(0, 2) == 0) ? 1 : 0,
                 int'($urandom_range(0, DEPTH - 1)), d,
                 ($urandom_range(0, 9) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 16, program buffer depth in 16-bit words (power of two, 2..256).
REQ-002 Localparam AW = clog2(DEPTH), address/PC width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_en  input  1  write load_data into the program buffer this cycle.
REQ-006 load_addr  input  AW  program buffer write address.
REQ-007 load_data  input  16  instruction word to store.
REQ-008 start  input  1  begin execution from address 0.
REQ-009 stall  input  1  downstream hold; suppresses issue and PC advance.
REQ-010 Instruction  output  16  issued instruction word to the datapath.
REQ-011 InitSel  output  1  datapath write-data select; 1 = ALU result, 0 = external init data.
REQ-012 instr_valid  output  1  Instruction is a new issue this cycle.
REQ-013 pc  output  AW  address of the next word to fetch.
REQ-014 halted  output  1  fetch stopped on a halt opcode.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and HALT.
REQ-016 IDLE: start=1 -> RUN with pc=0; otherwise remain.
REQ-017 RUN, stall=0: Instruction <= mem[pc], instr_valid <= 1, pc <= pc+1 (1-cycle latency from pc to Instruction).
REQ-018 RUN, stall=1: Instruction, pc and InitSel held; instr_valid <= 0.
REQ-019 pc SHALL wrap from DEPTH-1 to 0 in RUN with no other side effect.
REQ-020 InitSel SHALL be 1 in RUN and 0 in IDLE and HALT.
REQ-021 Outside RUN, Instruction SHALL be 16'h0000 and instr_valid 0.
REQ-022 load_en SHALL write mem[load_addr] in IDLE and HALT; it SHALL be ignored in RUN.
REQ-023 load_en and start in the same IDLE cycle: the write completes, and the first fetch (the following cycle) sees the written data.
REQ-024 start and stall in the same IDLE cycle: enter RUN, first issue deferred until stall=0.
REQ-025 HALT: halted=1, pc holds the halt word's address; start=1 -> RUN with pc=0 and halted <= 0.
REQ-026 start SHALL be ignored in RUN.

Reset
REQ-027 reset=1 at any edge, including mid-RUN: state IDLE, pc=0, Instruction=16'h0000, instr_valid=0, InitSel=0, halted=0.
REQ-028 Program buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro FETCH_HALT_OP_EN defined: in RUN with stall=0, a fetched word with [15:12]=4'hF is not issued; instr_valid=0, Instruction=16'h0000, pc holds, state -> HALT.
REQ-030 FETCH_HALT_OP_EN undefined: opcode 4'hF is issued like any other word, HALT is unreachable, and halted is tied 0.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the FSM state enum, HALT_OPCODE = 4'hF and NOP_WORD = 16'h0000.
REQ-032 The program buffer SHALL be a sub-module prog_mem: synchronous write, asynchronous read, parameterised by DEPTH.

Verification
REQ-033 Load mem[0..2] = 16'h1123, 16'h2456, 16'h3789, then start -> Instruction shows 1123, 2456, 3789 on 3 consecutive cycles after the start edge+1, instr_valid=1, InitSel=1.
REQ-034 stall=1 for 2 cycles after the first issue -> Instruction holds 16'h1123, instr_valid=0 for 2 cycles, pc stays 1, and 2456 is issued on the cycle after stall falls.
REQ-035 With FETCH_HALT_OP_EN, mem[3] = 16'hF000 -> after 3789, halted=1, pc=3, InitSel=0, instr_valid=0; start then reissues from 1123.
REQ-036 Without FETCH_HALT_OP_EN, DEPTH=4 run for 6 issues -> words at addresses 0,1,2,3,0,1 issued, F000 included, and halted stays 0.
REQ-037 reset asserted in the middle of a RUN -> next cycle IDLE, pc=0, Instruction=0, InitSel=0, and buffer contents unchanged, as shown by a subsequent start issuing 1123.
REQ-038 load_en in RUN to address 1 with 16'hAAAA -> no change, and the next wrap re-issues 16'h2456.
